// File: rtl/issue_interlock_pkg.sv
// Shared constants and the per-lane decoded-instruction record for the issue interlock.
package issue_interlock_pkg;
  localparam int LANES  = 4;
  localparam int NREGS  = 32;
  localparam int NPREDS = 3;
  localparam int RW     = 5;
  localparam int PW     = 2;

  typedef struct packed {
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [PW-1:0] pred;
    logic [RW-1:0] rd;
    logic          rs_used;
    logic          rt_used;
    logic          pred_used;
    logic          rd_we;
    logic          pred_we;
  } lane_dec_t;

  typedef enum logic {S_EMPTY, S_HELD} state_e;
endpackage

// File: rtl/issue_interlock_if.sv
// Decode/scoreboard/execute signal bundle for the issue interlock.
interface issue_interlock_if;
  import issue_interlock_pkg::*;
  logic                       dec_valid;
  logic                       dec_ready;
  logic [LANES-1:0][RW-1:0]   dec_rs_num;
  logic [LANES-1:0][RW-1:0]   dec_rt_num;
  logic [LANES-1:0]           dec_rs_used;
  logic [LANES-1:0]           dec_rt_used;
  logic [LANES-1:0][PW-1:0]   dec_pred_num;
  logic [LANES-1:0]           dec_pred_used;
  logic [LANES-1:0][RW-1:0]   dec_rd_num;
  logic [LANES-1:0]           dec_rd_we;
  logic [LANES-1:0]           dec_pred_we;
  logic                       flush;
  logic [NREGS-1:0]           sb2d_reg_scoreboard;
  logic [NPREDS-1:0]          sb2d_pred_scoreboard;
  logic                       ex_ready;
  logic                       iss_valid;
  logic [RW-1:0]              d2pc_out_rd_num0, d2pc_out_rd_num1, d2pc_out_rd_num2, d2pc_out_rd_num3;
  logic                       d2pc_out_rd_we0, d2pc_out_rd_we1, d2pc_out_rd_we2, d2pc_out_rd_we3;
  logic                       d2pc_out_pred_we0, d2pc_out_pred_we1, d2pc_out_pred_we2, d2pc_out_pred_we3;
  logic [31:0]                stall_cycles;

  modport slave (
    input  dec_valid, dec_rs_num, dec_rt_num, dec_rs_used, dec_rt_used, dec_pred_num,
           dec_pred_used, dec_rd_num, dec_rd_we, dec_pred_we, flush,
           sb2d_reg_scoreboard, sb2d_pred_scoreboard, ex_ready,
    output dec_ready, iss_valid,
           d2pc_out_rd_num0, d2pc_out_rd_num1, d2pc_out_rd_num2, d2pc_out_rd_num3,
           d2pc_out_rd_we0, d2pc_out_rd_we1, d2pc_out_rd_we2, d2pc_out_rd_we3,
           d2pc_out_pred_we0, d2pc_out_pred_we1, d2pc_out_pred_we2, d2pc_out_pred_we3,
           stall_cycles
  );

  modport master (
    output dec_valid, dec_rs_num, dec_rt_num, dec_rs_used, dec_rt_used, dec_pred_num,
           dec_pred_used, dec_rd_num, dec_rd_we, dec_pred_we, flush,
           sb2d_reg_scoreboard, sb2d_pred_scoreboard, ex_ready,
    input  dec_ready, iss_valid,
           d2pc_out_rd_num0, d2pc_out_rd_num1, d2pc_out_rd_num2, d2pc_out_rd_num3,
           d2pc_out_rd_we0, d2pc_out_rd_we1, d2pc_out_rd_we2, d2pc_out_rd_we3,
           d2pc_out_pred_we0, d2pc_out_pred_we1, d2pc_out_pred_we2, d2pc_out_pred_we3,
           stall_cycles
  );
endinterface

// File: rtl/issue_interlock_hazard_check.sv
// Combinational RAW/WAW reduction of a held bundle against the busy register/predicate masks.
module issue_interlock_hazard_check
  import issue_interlock_pkg::*;
(
  input  lane_dec_t [LANES-1:0] i_bundle,
  input  logic [NREGS-1:0]      i_busy_reg,
  input  logic [NPREDS-1:0]     i_busy_pred,
  output logic                  o_hazard
);
  // Pad to the full 2-bit index space; predicate 3 is the always-true slot and never pending.
  logic [(2**PW)-1:0] w_busy_pred;
  logic [LANES-1:0]   w_lane_haz;

  assign w_busy_pred = {{((2**PW)-NPREDS){1'b0}}, i_busy_pred};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_haz[g] =
        (i_bundle[g].rs_used   & i_busy_reg[i_bundle[g].rs])   |
        (i_bundle[g].rt_used   & i_busy_reg[i_bundle[g].rt])   |
        (i_bundle[g].pred_used & w_busy_pred[i_bundle[g].pred]) |
        (i_bundle[g].rd_we     & i_busy_reg[i_bundle[g].rd])   |
        (i_bundle[g].pred_we   & w_busy_pred[i_bundle[g].rd[PW-1:0]]);
  end

  assign o_hazard = |w_lane_haz;
endmodule

// File: rtl/issue_interlock.sv
// One-deep issue stage: holds a decoded bundle until the scoreboard (plus a one-cycle
// shadow of the last issue's destinations) shows no pending source or destination.
module issue_interlock
  import issue_interlock_pkg::*;
(
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst,
  issue_interlock_if.slave  bus
);
  state_e                    r_state, w_state_nxt;
  lane_dec_t [LANES-1:0]     w_dec, r_bundle;
  logic [NREGS-1:0]          r_shadow_reg, w_iss_reg;
  logic [NPREDS-1:0]         r_shadow_pred, w_iss_pred;
  logic                      w_hazard, w_fire, w_dec_ready, w_accept;
  logic                      r_iss_valid;
  logic [LANES-1:0][RW-1:0]  r_out_rd;
  logic [LANES-1:0]          r_out_we, r_out_pwe;
  logic [31:0]               r_stall;

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign w_dec[g].rs        = bus.dec_rs_num[g];
    assign w_dec[g].rt        = bus.dec_rt_num[g];
    assign w_dec[g].pred      = bus.dec_pred_num[g];
    assign w_dec[g].rd        = bus.dec_rd_num[g];
    assign w_dec[g].rs_used   = bus.dec_rs_used[g];
    assign w_dec[g].rt_used   = bus.dec_rt_used[g];
    assign w_dec[g].pred_used = bus.dec_pred_used[g];
    assign w_dec[g].rd_we     = bus.dec_rd_we[g];
    assign w_dec[g].pred_we   = bus.dec_pred_we[g];
  end

  issue_interlock_hazard_check u_hazard (
    .i_bundle    (r_bundle),
    .i_busy_reg  (bus.sb2d_reg_scoreboard | r_shadow_reg),
    .i_busy_pred (bus.sb2d_pred_scoreboard | r_shadow_pred),
    .o_hazard    (w_hazard)
  );

  assign w_fire      = (r_state == S_HELD) && !w_hazard && bus.ex_ready;
  assign w_dec_ready = !clkrst_core_rst && !bus.flush && ((r_state == S_EMPTY) || w_fire);
  assign w_accept    = bus.dec_valid && w_dec_ready;

  // Flush always empties the stage; an issue in the same cycle still goes out.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_HELD;
      S_HELD: begin
        if (bus.flush)                w_state_nxt = S_EMPTY;
        else if (w_fire && !w_accept) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    w_iss_reg  = '0;
    w_iss_pred = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_bundle[i].rd_we) w_iss_reg[r_bundle[i].rd] = 1'b1;
      if (r_bundle[i].pred_we && (r_bundle[i].rd[PW-1:0] < PW'(NPREDS)))
        w_iss_pred[r_bundle[i].rd[PW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_state       <= S_EMPTY;
      r_bundle      <= '0;
      r_shadow_reg  <= '0;
      r_shadow_pred <= '0;
      r_iss_valid   <= 1'b0;
      r_out_rd      <= '0;
      r_out_we      <= '0;
      r_out_pwe     <= '0;
      r_stall       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)                    r_bundle <= w_dec;
      else if (w_state_nxt == S_EMPTY) r_bundle <= '0;
      r_shadow_reg  <= w_fire ? w_iss_reg  : '0;
      r_shadow_pred <= w_fire ? w_iss_pred : '0;
      r_iss_valid   <= w_fire;
      for (int i = 0; i < LANES; i++) begin
        r_out_rd[i]  <= w_fire ? r_bundle[i].rd : '0;
        r_out_we[i]  <= w_fire & r_bundle[i].rd_we;
        r_out_pwe[i] <= w_fire & r_bundle[i].pred_we;
      end
      if ((r_state == S_HELD) && w_hazard && (r_stall != '1))
        r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.dec_ready         = w_dec_ready;
  assign bus.iss_valid         = r_iss_valid;
  assign bus.d2pc_out_rd_num0  = r_out_rd[0];
  assign bus.d2pc_out_rd_num1  = r_out_rd[1];
  assign bus.d2pc_out_rd_num2  = r_out_rd[2];
  assign bus.d2pc_out_rd_num3  = r_out_rd[3];
  assign bus.d2pc_out_rd_we0   = r_out_we[0];
  assign bus.d2pc_out_rd_we1   = r_out_we[1];
  assign bus.d2pc_out_rd_we2   = r_out_we[2];
  assign bus.d2pc_out_rd_we3   = r_out_we[3];
  assign bus.d2pc_out_pred_we0 = r_out_pwe[0];
  assign bus.d2pc_out_pred_we1 = r_out_pwe[1];
  assign bus.d2pc_out_pred_we2 = r_out_pwe[2];
  assign bus.d2pc_out_pred_we3 = r_out_pwe[3];
  assign bus.stall_cycles      = r_stall;
endmodule

// File: tb/tb_issue_interlock.sv
// Directed bench: expected issue records are queued at stimulus time and popped by a monitor.
module tb_issue_interlock;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct packed {
    logic [3:0][4:0] rd;
    logic [3:0]      we;
    logic [3:0]      pwe;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;

  issue_interlock_if bus();

  issue_interlock dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .bus             (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_bundle();
    bus.dec_rs_num = '0;  bus.dec_rt_num = '0;  bus.dec_rs_used = '0; bus.dec_rt_used = '0;
    bus.dec_pred_num = '0; bus.dec_pred_used = '0; bus.dec_rd_num = '0;
    bus.dec_rd_we = '0;   bus.dec_pred_we = '0;
    cur_exp = '0;
  endtask

  task automatic set_lane(input int l, input logic [4:0] rs, input logic rsu,
                          input logic [4:0] rt, input logic rtu, input logic [1:0] pr,
                          input logic pru, input logic [4:0] rd, input logic rdwe,
                          input logic prwe);
    bus.dec_rs_num[l] = rs;   bus.dec_rs_used[l] = rsu;
    bus.dec_rt_num[l] = rt;   bus.dec_rt_used[l] = rtu;
    bus.dec_pred_num[l] = pr; bus.dec_pred_used[l] = pru;
    bus.dec_rd_num[l] = rd;   bus.dec_rd_we[l] = rdwe; bus.dec_pred_we[l] = prwe;
    cur_exp.rd[l] = rd; cur_exp.we[l] = rdwe; cur_exp.pwe[l] = prwe;
  endtask

  // One cycle: sample at negedge, then return just after the next rising edge.
  task automatic cyc(input int iv, input int st, input int rdy, input string nm);
    @(negedge clk);
    check({nm, "_iss_valid"}, 32'(bus.iss_valid), 32'(iv));
    if (st >= 0)  check({nm, "_stall_cycles"}, bus.stall_cycles, 32'(st));
    if (rdy >= 0) check({nm, "_dec_ready"}, 32'(bus.dec_ready), 32'(rdy));
    @(posedge clk); #1;
  endtask

  // Monitor: every issue must match the oldest queued expectation; no stray enables.
  always @(negedge clk) begin
    if (!rst && bus.iss_valid) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_issue", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_rd_num", 32'({bus.d2pc_out_rd_num3, bus.d2pc_out_rd_num2,
                                 bus.d2pc_out_rd_num1, bus.d2pc_out_rd_num0}), 32'(e.rd));
        check("mon_rd_we", 32'({bus.d2pc_out_rd_we3, bus.d2pc_out_rd_we2,
                                bus.d2pc_out_rd_we1, bus.d2pc_out_rd_we0}), 32'(e.we));
        check("mon_pred_we", 32'({bus.d2pc_out_pred_we3, bus.d2pc_out_pred_we2,
                                  bus.d2pc_out_pred_we1, bus.d2pc_out_pred_we0}), 32'(e.pwe));
      end
    end else if (!bus.iss_valid) begin
      if (|{bus.d2pc_out_rd_we3, bus.d2pc_out_rd_we2, bus.d2pc_out_rd_we1, bus.d2pc_out_rd_we0,
            bus.d2pc_out_pred_we3, bus.d2pc_out_pred_we2, bus.d2pc_out_pred_we1,
            bus.d2pc_out_pred_we0})
        check("mon_we_without_valid", 32'd1, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dec_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
    bus.sb2d_reg_scoreboard = '0; bus.sb2d_pred_scoreboard = '0;
    clr_bundle();

    // Reset state
    #1;
    check("rst_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 1, "rst_release");

    // T1: simple issue, visible 2 cycles after dec_valid
    set_lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    bus.dec_valid = 1'b1; exp_q.push_back(cur_exp);
    cyc(0, 0, 1, "t1_c0");
    bus.dec_valid = 1'b0; clr_bundle();
    cyc(0, 0, 1, "t1_c1");
    cyc(1, 0, 1, "t1_c2");
    cyc(0, 0, 1, "t1_c3");

    // T2: RAW on r8 held 3 cycles
    bus.sb2d_reg_scoreboard = 32'h0000_0100;
    set_lane(1, 5'd8, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.dec_valid = 1'b1; exp_q.push_back(cur_exp);
    cyc(0, 0, 1, "t2_c0");
    bus.dec_valid = 1'b0; clr_bundle();
    cyc(0, 0, 0, "t2_c1");
    cyc(0, 1, 0, "t2_c2");
    cyc(0, 2, 0, "t2_c3");
    bus.sb2d_reg_scoreboard = '0;
    cyc(0, 3, 1, "t2_c4");
    cyc(1, 3, 1, "t2_c5");

    // T3: back-to-back, shadow blocks the dependent bundle one cycle
    set_lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    bus.dec_valid = 1'b1; exp_q.push_back(cur_exp);
    cyc(0, 3, 1, "t3_c0");
    clr_bundle();
    set_lane(0, 5'd7, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_q.push_back(cur_exp);
    cyc(0, 3, 1, "t3_c1");
    bus.dec_valid = 1'b0; clr_bundle();
    cyc(1, 3, 0, "t3_c2");
    cyc(0, 4, 1, "t3_c3");
    cyc(1, 4, 1, "t3_c4");

    // T4: predicate WAW stalls; predicate 3 never stalls
    bus.sb2d_pred_scoreboard = 3'b010;
    set_lane(2, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd1, 1'b0, 1'b1);
    bus.dec_valid = 1'b1; exp_q.push_back(cur_exp);
    cyc(0, 4, 1, "t4_c0");
    bus.dec_valid = 1'b0; clr_bundle();
    cyc(0, 4, 0, "t4_c1");
    bus.sb2d_pred_scoreboard = '0;
    cyc(0, 5, 1, "t4_c2");
    cyc(1, 5, -1, "t4_c3");
    bus.sb2d_pred_scoreboard = 3'b111;
    set_lane(0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    bus.dec_valid = 1'b1; exp_q.push_back(cur_exp);
    cyc(0, 5, 1, "t4_p3_c0");
    bus.dec_valid = 1'b0; clr_bundle();
    cyc(0, 5, 1, "t4_p3_c1");
    cyc(1, 5, 1, "t4_p3_c2");
    bus.sb2d_pred_scoreboard = '0;

    // T5: flush while stalled
    bus.sb2d_reg_scoreboard = 32'h0000_0100;
    set_lane(0, 5'd8, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.dec_valid = 1'b1;
    cyc(0, 5, 1, "t5_c0");
    bus.dec_valid = 1'b0; clr_bundle();
    cyc(0, 5, 0, "t5_c1");
    bus.flush = 1'b1;
    cyc(0, 6, 0, "t5_flush");
    bus.flush = 1'b0;
    cyc(0, 7, 1, "t5_c3");
    cyc(0, 7, 1, "t5_c4");

    // T6: asynchronous reset mid-stall
    set_lane(0, 5'd8, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    bus.dec_valid = 1'b1;
    cyc(0, 7, 1, "t6_c0");
    bus.dec_valid = 1'b0; clr_bundle();
    cyc(0, 7, 0, "t6_c1");
    cyc(0, 8, 0, "t6_c2");
    #2 rst = 1'b1;
    #1;
    check("t6_rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    check("t6_rst_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("t6_rst_stall", bus.stall_cycles, 32'd0);
    check("t6_rst_rd_we", 32'({bus.d2pc_out_rd_we3, bus.d2pc_out_rd_we2,
                                bus.d2pc_out_rd_we1, bus.d2pc_out_rd_we0}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.sb2d_reg_scoreboard = '0;
    cyc(0, 0, 1, "t6_post0");
    cyc(0, 0, 1, "t6_post1");

    // T7: ex_ready low without hazard holds but does not count stalls
    bus.ex_ready = 1'b0;
    set_lane(3, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd31, 1'b1, 1'b0);
    set_lane(1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd2, 1'b0, 1'b1);
    bus.dec_valid = 1'b1; exp_q.push_back(cur_exp);
    cyc(0, 0, 1, "t7_c0");
    bus.dec_valid = 1'b0; clr_bundle();
    cyc(0, 0, 0, "t7_c1");
    cyc(0, 0, 0, "t7_c2");
    bus.ex_ready = 1'b1;
    cyc(0, 0, 1, "t7_c3");
    cyc(1, 0, 1, "t7_c4");
    cyc(0, 0, 1, "t7_c5");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
